// File: rtl/seq_add_64_pkg.sv
// Shared definitions for the multi-cycle 64-bit adder: FSM encodings and default width.
package seq_add_64_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 64;

endpackage

// File: rtl/seq_add_64_slice_add.sv
// Combinational W-bit adder with carry in and carry out; one slice of the sequential adder.
module slice_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_add_64.sv
// Multi-cycle two's-complement adder: one CHUNK-bit slice per cycle with a registered
// ripple carry, producing sum, carry-out and Y86 condition flags behind valid/ready.
module seq_add_64
  import seq_add_64_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v,
  output logic             zf,
  output logic             sf
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg, sum_next;
  logic [KW-1:0]      k_reg;
  logic               carry_reg, cout_reg, v_reg, zf_reg, sf_reg;
  logic [CHUNK-1:0]   a_slices [NSLICE];
  logic [CHUNK-1:0]   b_slices [NSLICE];
  logic [CHUNK-1:0]   slice_sum;
  logic               slice_carry;
  logic               last;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
    assign a_slices[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_slices[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  // A single slice adder is time-shared; the counter selects which slice it sees.
  slice_add #(.W(CHUNK)) u_slice_add (
    .a    (a_slices[k_reg]),
    .b    (b_slices[k_reg]),
    .cin  (carry_reg),
    .s    (slice_sum),
    .cout (slice_carry)
  );

  assign last = (k_reg == K_LAST);

  always_comb begin
    sum_next = sum_reg;
    sum_next[k_reg*CHUNK +: CHUNK] = slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_RUN;
      end
      S_RUN:  if (last) state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      k_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      v_reg     <= 1'b0;
      zf_reg    <= 1'b0;
      sf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (in_valid) begin
          a_reg     <= a;
          b_reg     <= b;
          k_reg     <= '0;
          carry_reg <= 1'b0;
        end
        S_RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= slice_carry;
          k_reg     <= k_reg + KW'(1);
          // Flags come from the freshly combined sum, not the stale register.
          if (last) begin
            cout_reg <= slice_carry;
            sf_reg   <= sum_next[WIDTH-1];
            zf_reg   <= (sum_next == '0);
            v_reg    <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign v    = v_reg;
  assign zf   = zf_reg;
  assign sf   = sf_reg;

endmodule

// File: tb/tb_seq_add_64.sv
// Randomized self-checking bench for seq_add_64 against a plain-arithmetic reference model.
module tb_seq_add_64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        cout, v, zf, sf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_add_64 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .v(v), .zf(zf), .sf(sf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return r;
      1: return r | 64'hFFFF_FFFF_FFFF_0000;
      2: return 64'($urandom_range(0, 100));
      default: return {r[63], {63{~r[63]}}};
    endcase
  endfunction

  // Reference model: full-precision arithmetic, flags from the mathematical result.
  task automatic model(input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] es, output logic ec, output logic ev,
                       output logic ez, output logic esf);
    logic [64:0] wide;
    wide = {1'b0, x} + {1'b0, y};
    es   = wide[63:0];
    ec   = wide[64];
    ev   = (x[63] == y[63]) && (es[63] != x[63]);
    ez   = (es == 64'd0);
    esf  = es[63];
  endtask

  task automatic do_op(input logic [63:0] x, input logic [63:0] y,
                       input int hold, input bit poke);
    logic [63:0] es;
    logic ec, ev, ez, esf;
    int lat;
    model(x, y, es, ec, ev, ez, esf);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rnd64(); b = rnd64();
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", 64'(lat), 64'd4);
    check("sum", sum, es);
    check("cout", 64'(cout), 64'(ec));
    check("v", 64'(v), 64'(ev));
    check("zf", 64'(zf), 64'(ez));
    check("sf", 64'(sf), 64'(esf));
    check("in_ready_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1; a = rnd64(); b = rnd64();
      end
      @(posedge clk); @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_sum", sum, es);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid", 64'(out_valid), 64'd0);
    check("back_idle", 64'(in_ready), 64'd1);
    check("idle_sum_held", sum, es);
    $display("op a=%h b=%h sum=%h c=%0b v=%0b z=%0b s=%0b hold=%0d lat=%0d",
             x, y, sum, cout, v, zf, sf, hold, lat);
  endtask

  initial begin
    #2;
    check("rst_sum", sum, 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_flags", 64'({cout, v, zf, sf}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    do_op(64'd5, 64'd7, 0, 1'b0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1'b0);
    do_op(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 10, 1'b1);

    for (int i = 0; i < 40; i++)
      do_op(rnd64(), rnd64(), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    // Reset in the middle of RUN, with slice 2 about to be added.
    do_op(64'hDEAD_BEEF_0000_1234, 64'h0000_0001_FFFF_0001, 0, 1'b0);
    @(negedge clk);
    a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sum", sum, 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_flags", 64'({cout, v, zf, sf}), 64'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    $display("reset mid-RUN sum=%h out_valid=%0b", sum, out_valid);
    do_op(64'd3, 64'd4, 1, 1'b0);
    check("fresh_sum", sum, 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_add_64.md
Name: seq_add_64

Overview:
- Multi-cycle 64-bit two's-complement adder: the additive counterpart to the subtract path.
- Adds operands in CHUNK-bit slices, one slice per cycle, rippling the carry through a register.
- Produces the sum, carry-out and Y86 condition flags (ZF, SF, OF) for the execute stage.
- Valid/ready handshakes on both sides let the stage hold inputs or stall on output.

Parameters:
- WIDTH, 64, operand and result width in bits.
- CHUNK, 16, slice width added per cycle. Must divide WIDTH evenly. NSLICE = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  signed augend.
- b  input  WIDTH  signed addend.
- out_valid  output  1  result registered and stable.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a+b modulo 2^WIDTH.
- cout  output  1  unsigned carry out of bit WIDTH-1.
- v  output  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
- zf  output  1  sum==0.
- sf  output  1  sum[MSB].

Behaviour:
- Reset: async on rst_n low, takes effect without clk.
  - State goes to IDLE; slice counter, carry register, sum, cout, v, zf, sf all 0.
  - out_valid=0, in_ready=1 once rst_n is high.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture a, b into operand registers, clear carry and counter, go to RUN.
- RUN: one slice per cycle, with the counter k running 0..NSLICE-1.
  - {c, s} = a_reg[k*CHUNK +: CHUNK] + b_reg[k*CHUNK +: CHUNK] + carry.
  - Write s into the sum slice; carry <= c.
  - On k==NSLICE-1:
    - cout <= c.
    - v from the MSBs (operand MSBs versus the new sum MSB).
    - sf <= new sum MSB.
    - zf <= (full new sum == 0), computed from the combined slices, not a stale register.
    - Go to DONE.
  - in_ready=0 throughout. in_valid is ignored.
- DONE:
  - out_valid=1. sum and flags are held stable.
  - When out_ready is high, go to IDLE and drop out_valid next cycle.
  - If out_ready is low, hold indefinitely.
- Latency: operands accepted at edge N, out_valid high after edge N+NSLICE (4 cycles at default).
- Throughput: one result per NSLICE+2 cycles. A new operand is accepted only in IDLE; there is no IDLE-bypass from DONE.
- Operand registers isolate the computation: a and b may change after acceptance without effect.
- sum/flags in IDLE and RUN:
  - They hold the previous result.
  - During RUN, sum slices update progressively, so consumers must qualify with out_valid.
- Wrap-around: the addition is modulo 2^WIDTH. cout and v are independent, and both may be set (e.g. MIN+MIN).
- rst_n asserted mid-RUN or in DONE: the result is discarded and the block returns immediately to the reset state.
- in_valid and out_ready are both high in DONE: only out_ready matters. The operand is not accepted until the cycle after the return to IDLE.
- X on in_valid in IDLE is a bench error; no protection is required.

Decomposition:
- Shared pipeline package/header:
  - FSM state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH=64 constant.
- One natural sub-module: slice_add, a CHUNK-bit combinational adder with cin/cout, instantiated once and reused each RUN cycle via the slice counter mux.
- The flag computation stays inline.

Test Plan:
- a=5, b=7, out_ready=1 -> out_valid 4 cycles after acceptance; sum=12; cout=0, v=0, zf=0, sf=0.
- a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> sum=64'h8000_0000_0000_0000; v=1, sf=1, cout=0, zf=0.
- a=64'hFFFF_FFFF_FFFF_FFFF (-1), b=1 -> sum=0; zf=1, cout=1, v=0; carry ripples through all 4 slices.
- a=b=64'h8000_0000_0000_0000 -> sum=0; cout=1, v=1, zf=1.
- Backpressure: out_ready held low 10 cycles after out_valid -> out_valid and sum stable for all 10 cycles; in_ready=0; in_valid pulses are ignored.
- rst_n pulsed low during RUN at slice 2 -> all outputs 0 asynchronously. After release, in_ready=1 and a fresh 3+4 computation yields sum=7.
